// File: rtl/systolic_feeder_4x4_if.sv
// Operand-feeder bus: block load handshake, start/status and the skewed
// north/west operand streams toward systolic_array_4x4.
interface systolic_feeder_4x4_if #(
  parameter int BIT_WIDTH = 16
);
  logic                   load_valid;
  logic                   load_ready;
  logic                   load_sel;
  logic [1:0]             load_idx;
  logic [4*BIT_WIDTH-1:0] load_data;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   acc_clr;
  logic                   feed_valid;
  logic [BIT_WIDTH-1:0]   north_out0, north_out1, north_out2, north_out3;
  logic [BIT_WIDTH-1:0]   west_out0, west_out1, west_out2, west_out3;

  modport master (
    output load_valid, load_sel, load_idx, load_data, start,
    input  load_ready, busy, done, acc_clr, feed_valid,
    input  north_out0, north_out1, north_out2, north_out3,
    input  west_out0, west_out1, west_out2, west_out3
  );

  modport slave (
    input  load_valid, load_sel, load_idx, load_data, start,
    output load_ready, busy, done, acc_clr, feed_valid,
    output north_out0, north_out1, north_out2, north_out3,
    output west_out0, west_out1, west_out2, west_out3
  );
endinterface

// File: rtl/systolic_feeder_4x4.sv
// Buffers one 4x4 A block (rows) and B block, then streams them diagonally skewed
// into the systolic array. Define FEEDER_TRANSPOSE_B_EN to load B row-major.
module systolic_feeder_4x4 #(
  parameter int BIT_WIDTH    = 16,
  parameter int FRAC_WIDTH   = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  systolic_feeder_4x4_if.slave bus
);

  if (FRAC_WIDTH < 0 || FRAC_WIDTH > BIT_WIDTH || DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15)
    begin : g_param_check
      $error("systolic_feeder_4x4: FRAC_WIDTH or DRAIN_CYCLES out of range");
    end

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [BIT_WIDTH-1:0] r_a [4][4];
  logic [BIT_WIDTH-1:0] r_b [4][4];
  logic [BIT_WIDTH-1:0] r_west [4];
  logic [BIT_WIDTH-1:0] r_north [4];
  logic                 r_acc_clr;
  logic                 r_feed_valid;
  logic                 r_done;

  logic                 w_load_en;
  logic [3:0]           w_step;
  logic [BIT_WIDTH-1:0] w_west [4];
  logic [BIT_WIDTH-1:0] w_north [4];

  assign w_load_en = bus.load_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned k = 0; k < 4; k++) begin
          r_a[i][k] <= '0;
          r_b[i][k] <= '0;
        end
      end
    end else if (w_load_en) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (!bus.load_sel) begin
          r_a[bus.load_idx][k] <= bus.load_data[k*BIT_WIDTH +: BIT_WIDTH];
        end else begin
`ifdef FEEDER_TRANSPOSE_B_EN
          r_b[bus.load_idx][k] <= bus.load_data[k*BIT_WIDTH +: BIT_WIDTH];
`else
          r_b[k][bus.load_idx] <= bus.load_data[k*BIT_WIDTH +: BIT_WIDTH];
`endif
        end
      end
    end
  end

  // Values for the feed step that becomes visible after the next edge;
  // lane i carries element k exactly when step == i + k.
  always_comb begin
    w_step = (r_state == S_FEED) ? r_cnt + 4'd1 : 4'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_west[i]  = '0;
      w_north[i] = '0;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (32'(w_step) == i + k) begin
          w_west[i]  = r_a[i][k];
          w_north[i] = r_b[k][i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_acc_clr    <= 1'b0;
      r_feed_valid <= 1'b0;
      r_done       <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_west[i]  <= '0;
        r_north[i] <= '0;
      end
    end else begin
      r_acc_clr    <= 1'b0;
      r_feed_valid <= 1'b0;
      r_done       <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_west[i]  <= '0;
        r_north[i] <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_CLEAR;
            r_acc_clr <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_state      <= S_FEED;
          r_cnt        <= '0;
          r_feed_valid <= 1'b1;
          r_west       <= w_west;
          r_north      <= w_north;
        end
        S_FEED: begin
          if (r_cnt == 4'd6) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
          end else begin
            r_cnt        <= r_cnt + 4'd1;
            r_feed_valid <= 1'b1;
            r_west       <= w_west;
            r_north      <= w_north;
          end
        end
        S_DRAIN: begin
          if (r_cnt == 4'(DRAIN_CYCLES - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.load_ready = (r_state == S_IDLE) && !rst;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.acc_clr    = r_acc_clr;
  assign bus.feed_valid = r_feed_valid;
  assign bus.west_out0  = r_west[0];
  assign bus.west_out1  = r_west[1];
  assign bus.west_out2  = r_west[2];
  assign bus.west_out3  = r_west[3];
  assign bus.north_out0 = r_north[0];
  assign bus.north_out1 = r_north[1];
  assign bus.north_out2 = r_north[2];
  assign bus.north_out3 = r_north[3];

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Directed bench for systolic_feeder_4x4: hand-computed skew table, replay,
// busy rejection, load/start overlap and mid-feed reset.
module tb_systolic_feeder_4x4;
  localparam int BW = 16;
  localparam int DC = 4;

  typedef struct {
    logic [BW-1:0] w [4];
    logic [BW-1:0] n [4];
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_feeder_4x4_if #(.BIT_WIDTH(BW)) bus ();

  systolic_feeder_4x4 #(
    .BIT_WIDTH(BW),
    .FRAC_WIDTH(8),
    .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] mA [4][4];
  logic [BW-1:0] mB [4][4];
  vec_t basic [7];
  vec_t cur [7];
  vec_t zv;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] get_w(input int i);
    case (i)
      0: return bus.west_out0;
      1: return bus.west_out1;
      2: return bus.west_out2;
      default: return bus.west_out3;
    endcase
  endfunction

  function automatic logic [BW-1:0] get_n(input int i);
    case (i)
      0: return bus.north_out0;
      1: return bus.north_out1;
      2: return bus.north_out2;
      default: return bus.north_out3;
    endcase
  endfunction

  task automatic chk_streams(input string tag, input vec_t e);
    for (int i = 0; i < 4; i++) begin
      chk16($sformatf("%s W%0d", tag, i), get_w(i), e.w[i]);
      chk16($sformatf("%s N%0d", tag, i), get_n(i), e.n[i]);
    end
  endtask

  // Expected skew from the current reference matrices.
  task automatic build_cur();
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 4; i++) begin
        cur[t].w[i] = (t >= i && t - i <= 3) ? mA[i][t-i] : '0;
        cur[t].n[i] = (t >= i && t - i <= 3) ? mB[t-i][i] : '0;
      end
    end
  endtask

  function automatic logic [4*BW-1:0] a_word(input int i);
    logic [4*BW-1:0] w;
    for (int k = 0; k < 4; k++) w[k*BW +: BW] = mA[i][k];
    return w;
  endfunction

  function automatic logic [4*BW-1:0] b_word(input int j);
    logic [4*BW-1:0] w;
    for (int k = 0; k < 4; k++) begin
`ifdef FEEDER_TRANSPOSE_B_EN
      w[k*BW +: BW] = mB[j][k];
`else
      w[k*BW +: BW] = mB[k][j];
`endif
    end
    return w;
  endfunction

  task automatic load_word(input logic sel, input int idx, input logic [4*BW-1:0] data);
    bus.load_valid = 1'b1;
    bus.load_sel   = sel;
    bus.load_idx   = 2'(idx);
    bus.load_data  = data;
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 4; i++) load_word(1'b0, i, a_word(i));
    for (int j = 0; j < 4; j++) load_word(1'b1, j, b_word(j));
  endtask

  // Starts a block (whatever load inputs the caller left set go in the same
  // edge) and checks every cycle against cur[] through to the return to IDLE.
  task automatic run_block(input string tag, input bit inject);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    @(negedge clk);
    chk1({tag, " clr acc_clr"}, bus.acc_clr, 1'b1);
    chk1({tag, " clr busy"}, bus.busy, 1'b1);
    chk1({tag, " clr ready"}, bus.load_ready, 1'b0);
    chk1({tag, " clr fv"}, bus.feed_valid, 1'b0);
    chk_streams({tag, " clr"}, zv);
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      chk1($sformatf("%s t%0d fv", tag, t), bus.feed_valid, 1'b1);
      chk1($sformatf("%s t%0d acc_clr", tag, t), bus.acc_clr, 1'b0);
      chk1($sformatf("%s t%0d ready", tag, t), bus.load_ready, 1'b0);
      chk_streams($sformatf("%s t%0d", tag, t), cur[t]);
      if (inject && t < 6) begin
        bus.start      = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_sel   = 1'(t);
        bus.load_idx   = 2'(t);
        bus.load_data  = 64'hDEAD_BEEF_CAFE_F00D;
      end else begin
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
      end
    end
    for (int d = 0; d < DC; d++) begin
      @(negedge clk);
      chk1($sformatf("%s drain%0d fv", tag, d), bus.feed_valid, 1'b0);
      chk1($sformatf("%s drain%0d done", tag, d), bus.done, 1'b0);
      chk1($sformatf("%s drain%0d busy", tag, d), bus.busy, 1'b1);
      chk_streams($sformatf("%s drain%0d", tag, d), zv);
    end
    @(negedge clk);
    chk1({tag, " done pulse"}, bus.done, 1'b1);
    chk1({tag, " done busy"}, bus.busy, 1'b1);
    @(negedge clk);
    chk1({tag, " post done"}, bus.done, 1'b0);
    chk1({tag, " post busy"}, bus.busy, 1'b0);
    chk1({tag, " post ready"}, bus.load_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    for (int i = 0; i < 4; i++) begin
      zv.w[i] = '0;
      zv.n[i] = '0;
    end
    basic[0] = '{w: '{16'h0100, 16'h0000, 16'h0000, 16'h0000}, n: '{16'h0100, 16'h0000, 16'h0000, 16'h0000}};
    basic[1] = '{w: '{16'h0200, 16'h0100, 16'h0000, 16'h0000}, n: '{16'h0100, 16'h0200, 16'h0000, 16'h0000}};
    basic[2] = '{w: '{16'h0300, 16'h0200, 16'h0100, 16'h0000}, n: '{16'h0100, 16'h0200, 16'h0300, 16'h0000}};
    basic[3] = '{w: '{16'h0400, 16'h0300, 16'h0200, 16'h0100}, n: '{16'h0100, 16'h0200, 16'h0300, 16'h0400}};
    basic[4] = '{w: '{16'h0000, 16'h0400, 16'h0300, 16'h0200}, n: '{16'h0000, 16'h0200, 16'h0300, 16'h0400}};
    basic[5] = '{w: '{16'h0000, 16'h0000, 16'h0400, 16'h0300}, n: '{16'h0000, 16'h0000, 16'h0300, 16'h0400}};
    basic[6] = '{w: '{16'h0000, 16'h0000, 16'h0000, 16'h0400}, n: '{16'h0000, 16'h0000, 16'h0000, 16'h0400}};

    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_sel   = 1'b0;
    bus.load_idx   = '0;
    bus.load_data  = '0;
    bus.start      = 1'b0;

    // Reset state
    @(negedge clk);
    chk1("rst ready", bus.load_ready, 1'b0);
    chk1("rst busy", bus.busy, 1'b0);
    chk1("rst done", bus.done, 1'b0);
    chk1("rst acc_clr", bus.acc_clr, 1'b0);
    chk1("rst fv", bus.feed_valid, 1'b0);
    chk_streams("rst", zv);
    rst = 1'b0;
    #1;
    chk1("rel ready", bus.load_ready, 1'b1);
    chk1("rel busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;

    // Basic block against the hand-computed table
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        mA[i][k] = 16'h0100 * 16'(k + 1);
        mB[k][i] = 16'h0100 * 16'(i + 1);
      end
    load_all();
    for (int t = 0; t < 7; t++) cur[t] = basic[t];
    run_block("basic", 1'b0);

    // Distinct data, overwritten indices, last B word loaded with start
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        mA[i][k] = 16'hA000 + 16'(i * 16 + k);
        mB[i][k] = 16'hB000 + 16'(i * 16 + k);
      end
    build_cur();
    @(posedge clk);
    #1;
    load_word(1'b0, 2, 64'h1111_2222_3333_4444);
    load_word(1'b1, 1, 64'h5555_6666_7777_8888);
    for (int i = 0; i < 4; i++) load_word(1'b0, i, a_word(i));
    for (int j = 0; j < 3; j++) load_word(1'b1, j, b_word(j));
    bus.load_valid = 1'b1;
    bus.load_sel   = 1'b1;
    bus.load_idx   = 2'd3;
    bus.load_data  = b_word(3);
    run_block("overlap", 1'b0);

    // start/load during FEED are ignored; replay shows unchanged buffers
    run_block("inject", 1'b1);
    run_block("replay", 1'b0);

    // Reset at FEED t=3
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c < 5; c++) @(negedge clk);
    chk_streams("pre-rst t3", cur[3]);
    #2 rst = 1'b1;
    #1;
    chk_streams("async rst", zv);
    chk1("async rst fv", bus.feed_valid, 1'b0);
    chk1("async rst busy", bus.busy, 1'b0);
    chk1("async rst done", bus.done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("FAIL no done after rst: got %0d pulses expected 0", done_seen);
    end
    chk1("after rst ready", bus.load_ready, 1'b1);

    // Buffers cleared by reset: a bare start streams zeros
    for (int t = 0; t < 7; t++) cur[t] = zv;
    run_block("cleared", 1'b0);

    // Fresh load after reset
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        mA[i][k] = 16'hC000 + 16'(i * 4 + k);
        mB[i][k] = 16'hD000 + 16'((i * 4 + k) * 3);
      end
    build_cur();
    load_all();
    run_block("reload", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
